inst_ram_loader: RTL and testbench
==================================

Name: inst_ram_loader

Overview:
- Boot-time loader upstream of the instruction RAM (inst_ram256x8) and the pipelined CPU (PPU).
- Accepts a byte stream over a valid/ready handshake and writes each byte to consecutive RAM addresses from 0.
- Zero-fills all unwritten locations, then releases the CPU through cpu_run.
- Replaces file-based RAM precharge with a synthesizable load path.

Parameters:
- ADDR_W, 8, RAM address width.
- DEPTH, 256, number of RAM byte locations; must equal 2**ADDR_W.
- DATA_W, 8, stream and RAM data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that arms a load.
- in_valid  in  1  stream byte present.
- in_data  in  DATA_W  stream byte.
- in_last  in  1  marks the final byte of the stream.
- in_ready  out  1  loader accepts a byte this cycle.
- ram_we  out  1  RAM write strobe, registered.
- ram_addr  out  ADDR_W  RAM write address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- cpu_run  out  1  CPU release; holds the PPU stalled while low.
- done  out  1  load complete.
- overflow_err  out  1  stream longer than DEPTH bytes.
- byte_count  out  ADDR_W+1  count of accepted stream bytes.
- checksum  out  DATA_W  modulo-2^DATA_W sum of accepted bytes.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; internal pointer 0.
- States: IDLE, LOAD, FILL, DONE, ERROR.
- IDLE:
  - in_ready=0.
  - start=1 moves to LOAD; pointer, byte_count and checksum clear to 0.
- LOAD:
  - in_ready=1 (combinational from state).
  - A beat is accepted when in_valid && in_ready.
  - On accept at edge E: ram_we=1, ram_addr=pointer, ram_wdata=in_data are valid in the cycle after E; byte_count+=1; checksum+=in_data (wraps); pointer+=1.
  - No accept in a cycle: ram_we=0 next cycle.
  - Accepted beat with in_last=1 at pointer<DEPTH-1: go to FILL with pointer=pointer+1.
  - Accepted beat with in_last=1 at pointer=DEPTH-1: go to DONE.
  - Accepted beat with in_last=0 at pointer=DEPTH-1: the byte is written, then go to ERROR.
- FILL:
  - in_ready=0.
  - Each cycle writes 0x00 at pointer (registered, same timing as LOAD), then pointer+=1.
  - After the write of address DEPTH-1 is issued, go to DONE.
  - byte_count and checksum are unchanged.
  - One write per cycle; no stalls.
- DONE:
  - done and cpu_run are registered from state==DONE, so both rise one cycle after entering DONE; ram_we is 0 in that cycle.
  - Both hold until reset; start is ignored.
- ERROR:
  - overflow_err=1 from the cycle after entry.
  - cpu_run=0, done=0, in_ready=0, ram_we=0.
  - start=1 clears overflow_err and re-arms LOAD exactly as from IDLE.
- start is ignored in LOAD and FILL.
- in_valid while in_ready=0 is ignored; no byte is dropped or counted.
- Minimum stream length is 1 byte (in_last on the first beat).
- The pointer never wraps; a 257th byte is impossible because in_ready=0 in ERROR.
- Reset mid-LOAD or mid-FILL: outputs return to 0 immediately; RAM contents are undefined and a new start is required.
- Latency: stream accept to ram_we is 1 cycle. Final write to cpu_run rising is 1 cycle.

Test Plan:
- Short load: start; bytes 0x01,0x02,0x03,0x04 (last on 0x04), in_valid steady.
  - Writes addr 0..3 with those bytes, then 252 zero writes at addr 4..255.
  - byte_count=4, checksum=0x0A.
  - cpu_run and done rise exactly one cycle after the addr-255 write.
- Back-pressure/gaps: same 4 bytes with in_valid low for 3 cycles between beats.
  - Identical RAM writes, with no ram_we during the gaps.
  - Extra in_valid pulses asserted during FILL produce no writes and no count change.
- Exact fit: 256 bytes 0x00..0xFF, last on 0xFF.
  - No FILL writes; byte_count=256; checksum=0x80; done=1.
- Overflow: 256 bytes with in_last never set.
  - All 256 bytes written, then overflow_err=1, cpu_run=0, in_ready=0.
  - A subsequent start followed by 2 bytes (last on the 2nd) completes with done=1 and overflow_err=0.
- Reset mid-FILL: assert rst_n=0 at FILL pointer 100.
  - All outputs go to 0 asynchronously.
  - After release the state is IDLE and start plus a new stream loads normally.
- Simultaneous events: start asserted in the same cycle as an accepted beat in LOAD, and start asserted in DONE.
  - Both are ignored: no counter clear and no state change.

Source files
------------

// File: rtl/inst_ram_loader.sv
// rtl/inst_ram_loader.sv - boot-time loader that streams bytes into the instruction RAM, zero-fills the rest, then releases the CPU
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start            single-cycle pulse that arms a load (honoured in IDLE and ERROR)
//   in_valid/in_data/in_last, in_ready   byte stream handshake
//   ram_we/ram_addr/ram_wdata            registered RAM write port
//   cpu_run, done    CPU release and load-complete flags
//   overflow_err     stream ran past the last RAM location
//   byte_count, checksum                 accepted byte count and modulo byte sum
module inst_ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   byte_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, DONE, ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
      byte_count   <= '0;
      checksum     <= '0;
    end else begin
      ram_we       <= 1'b0;
      // Status flags track the current state, so they rise one cycle after entry.
      done         <= (state == DONE);
      cpu_run      <= (state == DONE);
      // A restart from ERROR drops the flag on the same edge that re-arms LOAD.
      overflow_err <= (state == ERROR) && !start;

      case (state)
        IDLE, ERROR: begin
          if (start) begin
            ptr        <= '0;
            byte_count <= '0;
            checksum   <= '0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          if (accept) begin
            ram_we     <= 1'b1;
            ram_addr   <= ptr;
            ram_wdata  <= in_data;
            byte_count <= byte_count + 1'b1;
            checksum   <= checksum + in_data;
            ptr        <= ptr + 1'b1;
            // The last location ends the load either way; only in_last decides
            // whether that is a clean finish or an over-long stream.
            if (ptr == LAST_ADDR) begin
              state <= in_last ? DONE : ERROR;
            end else if (in_last) begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          ram_we    <= 1'b1;
          ram_addr  <= ptr;
          ram_wdata <= '0;
          ptr       <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state <= DONE;
          end
        end

        DONE: begin
          // Terminal until reset.
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// tb/tb_inst_ram_loader.sv - self-checking bench for inst_ram_loader
module tb_inst_ram_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_run;
  logic       done;
  logic       overflow_err;
  logic [8:0] byte_count;
  logic [7:0] checksum;

  inst_ram_loader #(.ADDR_W(8), .DEPTH(256), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_run(cpu_run), .done(done), .overflow_err(overflow_err),
    .byte_count(byte_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Write monitor: RAM image, per-address write counts and release timing.
  logic [7:0] mem [256];
  int         wcnt [256];
  int         total_wr;
  int         cyc;
  int         last_wr_cyc;
  int         run_cyc;
  logic       run_seen;
  logic       run_we;
  logic       mon_clr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int a = 0; a < 256; a++) begin
        mem[a]  <= 8'hXX;
        wcnt[a] <= 0;
      end
      total_wr    <= 0;
      last_wr_cyc <= -100;
      run_cyc     <= -1;
      run_seen    <= 1'b0;
      run_we      <= 1'b1;
    end else begin
      if (ram_we) begin
        mem[ram_addr]  <= ram_wdata;
        wcnt[ram_addr] <= wcnt[ram_addr] + 1;
        total_wr       <= total_wr + 1;
        if (ram_addr == 8'hFF) last_wr_cyc <= cyc;
      end
      if (cpu_run && !run_seen) begin
        run_seen <= 1'b1;
        run_cyc  <= cyc;
        run_we   <= ram_we;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  // Pulse start, then offer n bytes first, first+1, ...; sidx marks a beat that also carries start.
  task automatic send_stream(input int n, input logic [7:0] first, input int gap,
                             input bit last, input int sidx);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit acc;
      int w;
      in_valid = 1'b1;
      in_data  = first + 8'(i);
      in_last  = last && (i == n - 1);
      start    = (i == sidx);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        w++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!acc) begin
        check("beat_accept", 0, 1);
        return;
      end
      repeat (gap) tick();
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] first;
    int         gap;
    bit         last;
    int         sidx;
    bit         fillp;
    bit         rst;
    int         exp_cnt;
    logic [7:0] exp_sum;
    bit         exp_done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    tests    = 0;
    failed   = 0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    mon_clr  = 1'b1;
    cyc      = 0;

    //          n    first  gap last sidx fillp rst cnt  sum    done
    vecs[0] = '{4,   8'h01, 0,  1,  -1,  0,    1,  4,   8'h0A, 1};  // short load
    vecs[1] = '{4,   8'h01, 3,  1,  -1,  1,    1,  4,   8'h0A, 1};  // gaps + FILL pulses
    vecs[2] = '{256, 8'h00, 0,  1,  -1,  0,    1,  256, 8'h80, 1};  // exact fit
    vecs[3] = '{256, 8'h10, 0,  0,  -1,  0,    1,  256, 8'h80, 0};  // overflow
    vecs[4] = '{2,   8'hFE, 0,  1,  -1,  0,    0,  2,   8'hFD, 1};  // restart from ERROR
    vecs[5] = '{1,   8'hA5, 0,  1,  -1,  0,    1,  1,   8'hA5, 1};  // one-byte stream
    vecs[6] = '{3,   8'h11, 0,  1,  1,   0,    1,  3,   8'h36, 1};  // start on accepted beat

    rst_n = 1'b0;
    #2;
    check("rst_async_we", int'(ram_we), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_mon();

    // Reset state
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 0);
    check("rst_cpu_run", int'(cpu_run), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow_err), 0);
    check("rst_byte_count", int'(byte_count), 0);
    check("rst_checksum", int'(checksum), 0);
    check("rst_in_ready", int'(in_ready), 0);

    // Reset in the middle of FILL
    begin
      bit found;
      send_stream(3, 8'h40, 0, 1, -1);
      found = 1'b0;
      for (int w = 0; w < 300 && !found; w++) begin
        @(negedge clk);
        if (ram_we && ram_addr == 8'd99) found = 1'b1;
      end
      check("midfill_reached", int'(found), 1);
      rst_n = 1'b0;
      #1;
      check("midfill_ram_we", int'(ram_we), 0);
      check("midfill_ram_addr", int'(ram_addr), 0);
      check("midfill_byte_count", int'(byte_count), 0);
      check("midfill_checksum", int'(checksum), 0);
      check("midfill_in_ready", int'(in_ready), 0);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) tick();
      check("idle_in_ready", int'(in_ready), 0);
      check("idle_byte_count", int'(byte_count), 0);
      check("idle_ram_we", int'(ram_we), 0);
      check("idle_done", int'(done), 0);
      in_valid = 1'b0;
    end

    // Table-driven loads
    for (int k = 0; k < 7; k++) begin
      bit fin;
      int bad;
      if (vecs[k].rst) do_reset();
      clear_mon();
      send_stream(vecs[k].n, vecs[k].first, vecs[k].gap, vecs[k].last, vecs[k].sidx);
      if (vecs[k].fillp) begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      fin = 1'b0;
      for (int w = 0; w < 700 && !fin; w++) begin
        @(negedge clk);
        if (done || overflow_err) fin = 1'b1;
      end
      check($sformatf("v%0d_finished", k), int'(fin), 1);
      repeat (3) tick();

      check($sformatf("v%0d_byte_count", k), int'(byte_count), vecs[k].exp_cnt);
      check($sformatf("v%0d_checksum", k), int'(checksum), int'(vecs[k].exp_sum));
      check($sformatf("v%0d_done", k), int'(done), int'(vecs[k].exp_done));
      check($sformatf("v%0d_cpu_run", k), int'(cpu_run), int'(vecs[k].exp_done));
      check($sformatf("v%0d_overflow", k), int'(overflow_err), int'(!vecs[k].exp_done));
      check($sformatf("v%0d_in_ready", k), int'(in_ready), 0);
      check($sformatf("v%0d_total_writes", k), total_wr, 256);

      bad = 0;
      for (int a = 0; a < 256; a++) begin
        logic [7:0] e;
        e = (a < vecs[k].n) ? vecs[k].first + 8'(a) : 8'h00;
        if (mem[a] !== e || wcnt[a] != 1) bad++;
      end
      check($sformatf("v%0d_ram_bad_addrs", k), bad, 0);

      if (vecs[k].exp_done) begin
        check($sformatf("v%0d_run_latency", k), run_cyc - last_wr_cyc, 1);
        check($sformatf("v%0d_run_we", k), int'(run_we), 0);
        // start while in DONE must change nothing
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check($sformatf("v%0d_done_start_done", k), int'(done), 1);
        check($sformatf("v%0d_done_start_count", k), int'(byte_count), vecs[k].exp_cnt);
        check($sformatf("v%0d_done_start_writes", k), total_wr, 256);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
